// File: rtl/req_his_table_if.sv
// Bus bundle for req_his_table: allocation, update, query, occupancy and timeout signals.
interface req_his_table_if #(
  parameter int TAG_COUNT     = 8,
  parameter int HIS_WIDTH     = 4,
  parameter int QUERY_PORTS   = 2,
  parameter int TIMEOUT_LIMIT = 1000
);
  localparam int HIS_WIDTH_I = (HIS_WIDTH > 0) ? HIS_WIDTH : 1;
  localparam int TAG_WIDTH   = $clog2(TAG_COUNT);
  localparam int CNT_WIDTH   = $clog2(TAG_COUNT + 1);

  logic                               alloc_req;
  logic [HIS_WIDTH_I-1:0]             alloc_his;
  logic                               alloc_gnt;
  logic [TAG_WIDTH-1:0]               alloc_tag;
  logic                               upd_vld;
  logic [TAG_WIDTH-1:0]               upd_tag;
  logic                               upd_last;
  logic [HIS_WIDTH_I-1:0]             upd_his;
  logic                               upd_err;
  logic [QUERY_PORTS*TAG_WIDTH-1:0]   query_tag;
  logic [QUERY_PORTS-1:0]             his_valid;
  logic [QUERY_PORTS*HIS_WIDTH_I-1:0] his_content;
  logic [CNT_WIDTH-1:0]               count;
  logic                               full;
  logic                               empty;
  logic                               timeout_tick;
  logic                               timeout_vld;
  logic [TAG_WIDTH-1:0]               timeout_tag;

  modport master (
    output alloc_req, alloc_his, upd_vld, upd_tag, upd_last, upd_his, query_tag, timeout_tick,
    input  alloc_gnt, alloc_tag, upd_err, his_valid, his_content, count, full, empty,
           timeout_vld, timeout_tag
  );

  modport slave (
    input  alloc_req, alloc_his, upd_vld, upd_tag, upd_last, upd_his, query_tag, timeout_tick,
    output alloc_gnt, alloc_tag, upd_err, his_valid, his_content, count, full, empty,
           timeout_vld, timeout_tag
  );
endinterface

// File: rtl/req_his_table.sv
// Outstanding-request tag table with per-tag history, multi-port query and occupancy tracking.
// Optional per-tag expiry timers are enabled by defining REQ_HIS_TIMEOUT_EN.
module req_his_entry #(
  parameter int HW            = 4,
  parameter bit STORE_HIS     = 1'b1,
  parameter int TO_W          = 10,
  parameter int TIMEOUT_LIMIT = 1000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set,
  input  logic          wr,
  input  logic          clr,
  input  logic          tick,
  input  logic [HW-1:0] set_his,
  input  logic [HW-1:0] wr_his,
  output logic          valid,
  output logic [HW-1:0] his,
  output logic          expired
);
  always_ff @(posedge clk) begin
    if (rst)      valid <= 1'b0;
    else if (set) valid <= 1'b1;
    else if (clr) valid <= 1'b0;
  end

  if (STORE_HIS) begin : g_his
    // History survives release so a late query still sees the last value.
    always_ff @(posedge clk) begin
      if (rst)      his <= '0;
      else if (set) his <= set_his;
      else if (wr)  his <= wr_his;
    end
  end else begin : g_nohis
    logic unused_his;
    assign unused_his = ^{set_his, wr_his};
    assign his = '0;
  end

`ifdef REQ_HIS_TIMEOUT_EN
  logic [TO_W-1:0] timer;
  always_ff @(posedge clk) begin
    if (rst)            timer <= '0;
    else if (set || wr) timer <= '0;
    else if (tick && valid && timer != TO_W'(TIMEOUT_LIMIT))
      timer <= timer + TO_W'(1);
  end
  assign expired = valid && (timer == TO_W'(TIMEOUT_LIMIT));
`else
  logic unused_tick;
  assign unused_tick = tick;
  assign expired = 1'b0;
`endif
endmodule

module req_his_table #(
  parameter int TAG_COUNT     = 8,
  parameter int HIS_WIDTH     = 4,
  parameter int QUERY_PORTS   = 2,
  parameter int TIMEOUT_LIMIT = 1000
) (
  input  logic           clk,
  input  logic           rst,
  req_his_table_if.slave bus
);
  localparam int HW        = (HIS_WIDTH > 0) ? HIS_WIDTH : 1;
  localparam int TAG_WIDTH = $clog2(TAG_COUNT);
  localparam int CNT_WIDTH = $clog2(TAG_COUNT + 1);
  localparam int TO_WIDTH  = $clog2(TIMEOUT_LIMIT + 1);

  logic [TAG_COUNT-1:0]         valid, expired, set_v, wr_v, clr_v;
  logic [TAG_COUNT-1:0][HW-1:0] his;
  logic [TAG_WIDTH-1:0]         free_tag, to_tag, to_tag_q;
  logic                         free_found, to_fire, to_vld_q, upd_err_q;
  logic                         upd_hit, upd_rel, upd_wr;
  logic [CNT_WIDTH-1:0]         cnt_q;

  assign upd_hit = bus.upd_vld && valid[bus.upd_tag];
  assign upd_rel = upd_hit && bus.upd_last;
  assign upd_wr  = upd_hit && !bus.upd_last;

  // Lowest free tag for allocation; lowest expired tag not hit by an update this cycle.
  always_comb begin
    free_tag   = '0;
    free_found = 1'b0;
    to_tag     = '0;
    to_fire    = 1'b0;
    for (int i = 0; i < TAG_COUNT; i++) begin
      if (!valid[i] && !free_found) begin
        free_tag   = TAG_WIDTH'(i);
        free_found = 1'b1;
      end
      if (expired[i] && !to_fire && !(upd_hit && bus.upd_tag == TAG_WIDTH'(i))) begin
        to_tag  = TAG_WIDTH'(i);
        to_fire = 1'b1;
      end
    end
  end

  assign bus.full      = (cnt_q == CNT_WIDTH'(TAG_COUNT));
  assign bus.empty     = (cnt_q == '0);
  assign bus.count     = cnt_q;
  assign bus.alloc_gnt = bus.alloc_req && !bus.full;
  assign bus.alloc_tag = free_tag;
  assign bus.upd_err   = upd_err_q;
  assign bus.timeout_vld = to_vld_q;
  assign bus.timeout_tag = to_tag_q;

  for (genvar t = 0; t < TAG_COUNT; t++) begin : g_tag
    assign set_v[t] = bus.alloc_gnt && (free_tag == TAG_WIDTH'(t));
    assign wr_v[t]  = upd_wr && (bus.upd_tag == TAG_WIDTH'(t));
    assign clr_v[t] = (upd_rel && bus.upd_tag == TAG_WIDTH'(t)) ||
                      (to_fire && to_tag == TAG_WIDTH'(t));
    req_his_entry #(
      .HW(HW), .STORE_HIS(HIS_WIDTH > 0), .TO_W(TO_WIDTH), .TIMEOUT_LIMIT(TIMEOUT_LIMIT)
    ) u_entry (
      .clk(clk), .rst(rst), .set(set_v[t]), .wr(wr_v[t]), .clr(clr_v[t]),
      .tick(bus.timeout_tick), .set_his(bus.alloc_his), .wr_his(bus.upd_his),
      .valid(valid[t]), .his(his[t]), .expired(expired[t])
    );
  end

  // Grant and release never hit the same tag, so the occupancy delta is a plain sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      upd_err_q <= 1'b0;
      to_vld_q  <= 1'b0;
      to_tag_q  <= '0;
    end else begin
      cnt_q     <= cnt_q + CNT_WIDTH'(bus.alloc_gnt) - CNT_WIDTH'(upd_rel) - CNT_WIDTH'(to_fire);
      upd_err_q <= bus.upd_vld && !valid[bus.upd_tag];
      to_vld_q  <= to_fire;
      to_tag_q  <= to_fire ? to_tag : '0;
    end
  end

  for (genvar p = 0; p < QUERY_PORTS; p++) begin : g_query
    logic [TAG_WIDTH-1:0] qt;
    assign qt = bus.query_tag[p*TAG_WIDTH +: TAG_WIDTH];
    assign bus.his_valid[p]          = valid[qt];
    assign bus.his_content[p*HW +: HW] = his[qt];
  end
endmodule

// File: tb/tb_req_his_table.sv
// Randomized scoreboard bench for req_his_table against a tag-set reference model.
module tb_req_his_table;
  localparam int TC = 8, HW = 4, QP = 2, TL = 4, TW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  req_his_table_if #(.TAG_COUNT(TC), .HIS_WIDTH(HW), .QUERY_PORTS(QP), .TIMEOUT_LIMIT(TL)) bus();
  req_his_table #(.TAG_COUNT(TC), .HIS_WIDTH(HW), .QUERY_PORTS(QP), .TIMEOUT_LIMIT(TL))
    dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    bit rst, areq, uv, ul, tick;
    int ahis, ut, uh;
    logic [QP*TW-1:0] qt;
  } stim_t;

  typedef struct {
    logic gnt, full, empty, uerr, tov;
    int tag, cnt, tot;
    logic [QP-1:0] hv;
    logic [QP*HW-1:0] hc;
  } exp_t;

  exp_t sbq[$];
  int checks = 0, errors = 0;

  // Reference model: set of live tags with history, age and pending registered flags.
  bit m_valid[TC];
  int m_his[TC];
  int m_tmr[TC];
  bit m_uerr, m_tov, m_known;
  int m_tot;

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < TC; i++) n += m_valid[i];
    return n;
  endfunction

  function automatic int m_free();
    for (int i = 0; i < TC; i++) if (!m_valid[i]) return i;
    return 0;
  endfunction

  task automatic m_advance(input stim_t s, input bit gnt, input int gtag);
    bit hit, fired;
    int ftag;
    if (s.rst) begin
      for (int i = 0; i < TC; i++) begin m_valid[i] = 0; m_his[i] = 0; m_tmr[i] = 0; end
      m_uerr = 0; m_tov = 0; m_tot = 0; m_known = 1;
      return;
    end
    hit = s.uv && m_valid[s.ut];
    fired = 0; ftag = 0;
`ifdef REQ_HIS_TIMEOUT_EN
    for (int i = 0; i < TC; i++)
      if (!fired && m_valid[i] && m_tmr[i] == TL && !(hit && s.ut == i)) begin fired = 1; ftag = i; end
    for (int i = 0; i < TC; i++)
      if (m_valid[i] && s.tick && m_tmr[i] < TL) m_tmr[i]++;
`endif
    if (gnt) begin m_valid[gtag] = 1; m_his[gtag] = s.ahis; m_tmr[gtag] = 0; end
    if (hit) begin
      if (s.ul) m_valid[s.ut] = 0;
      else begin m_his[s.ut] = s.uh; m_tmr[s.ut] = 0; end
    end
    if (fired) m_valid[ftag] = 0;
    m_uerr = s.uv && !hit;
    m_tov  = fired;
    m_tot  = fired ? ftag : 0;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.areq = 0; s.uv = 0; s.ul = 0; s.tick = 0;
    s.ahis = 0; s.ut = 0; s.uh = 0;
    s.qt = (QP*TW)'($urandom);
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    int qtp;
    @(posedge clk); #1;
    rst            = s.rst;
    bus.alloc_req  = s.areq;
    bus.alloc_his  = HW'(s.ahis);
    bus.upd_vld    = s.uv;
    bus.upd_tag    = TW'(s.ut);
    bus.upd_last   = s.ul;
    bus.upd_his    = HW'(s.uh);
    bus.query_tag  = s.qt;
    bus.timeout_tick = s.tick;
    e.gnt = s.areq && (m_count() != TC);
    e.tag = m_free();
    if (m_known) begin
      for (int p = 0; p < QP; p++) begin
        qtp = int'(s.qt[p*TW +: TW]);
        e.hv[p] = m_valid[qtp];
        e.hc[p*HW +: HW] = HW'(m_his[qtp]);
      end
      e.cnt = m_count(); e.full = (e.cnt == TC); e.empty = (e.cnt == 0);
      e.uerr = m_uerr; e.tov = m_tov; e.tot = m_tot;
      sbq.push_back(e);
    end
    m_advance(s, e.gnt, e.tag);
  endtask

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", n, $time, act, exp);
    end
  endtask

  // Monitor: one expected record per driven cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("alloc_gnt", int'(bus.alloc_gnt), int'(e.gnt));
        if (e.gnt) chk("alloc_tag", int'(bus.alloc_tag), e.tag);
        chk("his_valid", int'(bus.his_valid), int'(e.hv));
        chk("his_content", int'(bus.his_content), int'(e.hc));
        chk("count", int'(bus.count), e.cnt);
        chk("full", int'(bus.full), int'(e.full));
        chk("empty", int'(bus.empty), int'(e.empty));
        chk("upd_err", int'(bus.upd_err), int'(e.uerr));
        chk("timeout_vld", int'(bus.timeout_vld), int'(e.tov));
        if (e.tov) chk("timeout_tag", int'(bus.timeout_tag), e.tot);
      end
    end
  end

  initial begin
    stim_t s;
    int live[$];
    bus.alloc_req = 0; bus.alloc_his = '0; bus.upd_vld = 0; bus.upd_tag = '0;
    bus.upd_last = 0; bus.upd_his = '0; bus.query_tag = '0; bus.timeout_tick = 0;
    m_known = 0;

    s = idle(); s.rst = 1; step(s); step(s);
    step(idle());

    // Fill the table with his = tag+3, then one request while full.
    for (int i = 0; i < 9; i++) begin
      s = idle(); s.areq = 1; s.ahis = (m_free() + 3) & 15; step(s);
    end
    // Release tag 2 while full and requesting, then re-request.
    s = idle(); s.areq = 1; s.uv = 1; s.ut = 2; s.ul = 1; step(s);
    s = idle(); s.areq = 1; s.ahis = 9; step(s);
    step(idle());
    // History rewrite of tag 5, read back on port 1.
    s = idle(); s.uv = 1; s.ut = 5; s.uh = 'hA; step(s);
    s = idle(); s.qt = {TW'(5), TW'(5)}; step(s);
    // Free tag 6, then update it while free.
    s = idle(); s.uv = 1; s.ut = 6; s.ul = 1; step(s);
    s = idle(); s.uv = 1; s.ut = 6; s.uh = 3; step(s);
    step(idle()); step(idle());
    // Reset colliding with a grant and a release.
    s = idle(); s.rst = 1; s.areq = 1; s.uv = 1; s.ut = 1; s.ul = 1; step(s);
    step(idle()); step(idle());

    // Randomized traffic, updates mostly aimed at live tags.
    for (int c = 0; c < 3000; c++) begin
      s = idle();
      s.rst  = ($urandom_range(0, 299) == 0);
      s.areq = $urandom_range(0, 1);
      s.ahis = $urandom_range(0, 15);
      s.tick = ($urandom_range(0, 9) < 7);
      s.uv   = $urandom_range(0, 1);
      s.ul   = $urandom_range(0, 1);
      s.uh   = $urandom_range(0, 15);
      live.delete();
      for (int i = 0; i < TC; i++) if (m_valid[i]) live.push_back(i);
      if (live.size() > 0 && $urandom_range(0, 4) != 0)
        s.ut = live[$urandom_range(0, live.size() - 1)];
      else
        s.ut = $urandom_range(0, TC - 1);
      step(s);
    end

    // Expiry sequence: live tags 1 and 3 aging under a tick every cycle.
    s = idle(); s.rst = 1; step(s);
    for (int i = 0; i < 4; i++) begin
      s = idle(); s.areq = 1; s.tick = 1; s.ahis = i; step(s);
    end
    s = idle(); s.tick = 1; s.uv = 1; s.ut = 0; s.ul = 1; step(s);
    s = idle(); s.tick = 1; s.uv = 1; s.ut = 2; s.ul = 1; step(s);
    for (int i = 0; i < 12; i++) begin
      s = idle(); s.tick = 1; step(s);
    end

    s = idle(); step(s);
    @(posedge clk); @(negedge clk); #1;
    chk("scoreboard_drain", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
